// File: rtl/simon_playback_ctrl.sv
// Playback sequencer for the Simon game: walks the stored pattern and shows each
// entry on the one-hot LEDs for ON_TICKS ticks, followed by an OFF_TICKS blank gap.
module simon_playback_ctrl #(
    parameter int DEPTH     = 4,
    parameter int AW        = 4,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          start,
    input  logic          abort,
    input  logic [AW:0]   length,
    output logic [AW-1:0] rd_addr,
    input  logic [1:0]    rd_data,
    output logic [3:0]    led,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, ON, OFF, DONE} state_t;

    localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_W    = (AW+1)'(1);
    localparam logic [7:0]  ON_LOAD  = 8'(ON_TICKS);
    localparam logic [7:0]  OFF_LOAD = 8'(OFF_TICKS);

    state_t        state, state_next;
    logic [AW-1:0] idx, idx_next;
    logic [AW:0]   len_eff, len_eff_next;
    logic [1:0]    cur, cur_next;
    logic [7:0]    counter, counter_next;
    logic [3:0]    led_next;
    logic          busy_next, done_next;
    logic [AW-1:0] rd_addr_next;
    logic          entry_end;
    logic          last_entry;

    // len_eff never exceeds DEPTH, so stopping at len_eff-1 keeps idx inside memory
    assign last_entry = ({1'b0, idx} == (len_eff - ONE_W));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            idx     <= '0;
            len_eff <= '0;
            cur     <= '0;
            counter <= '0;
            led     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_addr <= '0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            len_eff <= len_eff_next;
            cur     <= cur_next;
            counter <= counter_next;
            led     <= led_next;
            busy    <= busy_next;
            done    <= done_next;
            rd_addr <= rd_addr_next;
        end
    end

    always_comb begin
        state_next   = state;
        idx_next     = idx;
        len_eff_next = len_eff;
        cur_next     = cur;
        counter_next = counter;
        entry_end    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    len_eff_next = (length > DEPTH_W) ? DEPTH_W : length;
                    idx_next     = '0;
                    state_next   = (len_eff_next == '0) ? DONE : FETCH;
                end
            end
            FETCH: state_next = LATCH;
            LATCH: begin
                cur_next     = rd_data;
                counter_next = ON_LOAD;
                state_next   = ON;
            end
            ON: begin
                if (tick) begin
                    counter_next = counter - 8'd1;
                    if (counter == 8'd1) begin
                        if (OFF_TICKS > 0) begin
                            counter_next = OFF_LOAD;
                            state_next   = OFF;
                        end else begin
                            entry_end = 1'b1;
                        end
                    end
                end
            end
            OFF: begin
                if (tick) begin
                    counter_next = counter - 8'd1;
                    if (counter == 8'd1) begin
                        entry_end = 1'b1;
                    end
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (entry_end) begin
            if (last_entry) begin
                state_next = DONE;
            end else begin
                idx_next   = idx + 1'b1;
                state_next = FETCH;
            end
        end

        if (abort && state != IDLE) begin
            state_next = IDLE;
        end
    end

    // Outputs are computed from the upcoming state so every output leaves a flop
    always_comb begin
        led_next     = (state_next == ON) ? (4'b0001 << cur_next) : 4'b0000;
        busy_next    = (state_next inside {FETCH, LATCH, ON, OFF});
        done_next    = (state_next == DONE);
        rd_addr_next = (state_next == FETCH) ? idx_next : rd_addr;
    end

endmodule

// File: tb/tb_simon_playback_ctrl.sv
// Directed bench for simon_playback_ctrl: a scoreboard queue holds the expected
// LED sequence and a negedge monitor pops and compares it as the LEDs change.
module tb_simon_playback_ctrl;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       start, start_ng;
    logic       abort;
    logic [4:0] length, length_ng;
    logic [3:0] rd_addr, rd_addr_ng;
    logic [1:0] rd_data, rd_data_ng;
    logic [3:0] led, led_ng;
    logic       busy, busy_ng;
    logic       done, done_ng;

    logic [1:0] mem    [16];
    logic [1:0] mem_ng [16];

    logic [3:0] exp_q [$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    int         lit_ticks = 0;
    logic [3:0] max_addr = '0;
    logic [3:0] led_prev = '0;
    bit         sb_en = 0;
    bit         lit_chk_en = 0;

    simon_playback_ctrl dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .abort(abort),
        .length(length), .rd_addr(rd_addr), .rd_data(rd_data),
        .led(led), .busy(busy), .done(done)
    );

    simon_playback_ctrl #(.OFF_TICKS(0)) dut_ng (
        .clk(clk), .reset(reset), .tick(tick), .start(start_ng), .abort(abort),
        .length(length_ng), .rd_addr(rd_addr_ng), .rd_data(rd_data_ng),
        .led(led_ng), .busy(busy_ng), .done(done_ng)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        rd_data    <= mem[rd_addr];
        rd_data_ng <= mem_ng[rd_addr_ng];
    end

    // One-cycle tick every 10 clocks, changed just after posedge so negedge sampling is stable
    initial begin
        tick = 1'b0;
        forever begin
            repeat (9) @(posedge clk);
            #2 tick = 1'b1;
            @(posedge clk);
            #2 tick = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [4:0] len);
        length = len;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic load_mem(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c, input logic [1:0] d);
        for (int i = 0; i < 16; i++) mem[i] = 2'd0;
        mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
    endtask

    task automatic push_exp(input logic [3:0] v);
        exp_q.push_back(v);
    endtask

    task automatic wait_for_led(input string tag, input logic [3:0] val);
        int n = 0;
        while (led !== val && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, 32'(led), 32'(val));
    endtask

    task automatic wait_for_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, 32'(done), 32'd1);
    endtask

    task automatic count_lit_ticks(output int ticks);
        int g = 0;
        ticks = 0;
        while (led_ng === 4'b0010 && g < 200) begin
            if (tick) ticks++;
            @(negedge clk);
            g++;
        end
    endtask

    // Scoreboard monitor: led changes are popped against the queue, plus per-cycle invariants
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (sb_en && led !== led_prev) begin
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("[TB] FAIL led_extra: observed %b required no change", led);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_output("led_seq", 32'(led), 32'(e));
                end
                if (lit_chk_en && led_prev != 4'b0 && led == 4'b0)
                    check_output("lit_ticks", 32'(lit_ticks), 32'd2);
                lit_ticks = 0;
            end
            if (led != 4'b0 && tick) lit_ticks++;
            if (done === 1'b1) begin
                done_cnt++;
                check_output("busy_on_done", 32'(busy), 32'd0);
            end
            if (busy === 1'b0) check_output("led_idle", 32'(led), 32'd0);
            if (rd_addr > max_addr) max_addr = rd_addr;
            led_prev = led;
        end
    end

    initial begin
        int t;
        int g;
        reset = 1'b0; start = 1'b0; abort = 1'b0; length = '0;
        start_ng = 1'b0; length_ng = '0;
        load_mem(2'd2, 2'd0, 2'd3, 2'd1);
        for (int i = 0; i < 16; i++) mem_ng[i] = 2'd0;
        mem_ng[0] = 2'd1; mem_ng[1] = 2'd1;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        check_output("rst_led", 32'(led), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_addr", 32'(rd_addr), 32'd0);

        $display("[TB] basic playback");
        sb_en = 1; lit_chk_en = 1; done_cnt = 0;
        push_exp(4'b0100); push_exp(4'b0000); push_exp(4'b0001); push_exp(4'b0000);
        push_exp(4'b1000); push_exp(4'b0000); push_exp(4'b0010); push_exp(4'b0000);
        apply_stimulus(5'd4);
        wait_for_done("basic_done");
        @(negedge clk);
        check_output("basic_done_pulse", 32'(done), 32'd0);
        check_output("basic_done_cnt", 32'(done_cnt), 32'd1);
        check_output("basic_q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] latency");
        push_exp(4'b0100); push_exp(4'b0000); push_exp(4'b0001); push_exp(4'b0000);
        push_exp(4'b1000); push_exp(4'b0000);
        apply_stimulus(5'd3);
        check_output("lat_addr", 32'(rd_addr), 32'd0);
        check_output("lat_busy", 32'(busy), 32'd1);
        check_output("lat_t1_led", 32'(led), 32'd0);
        @(negedge clk);
        check_output("lat_t2_led", 32'(led), 32'd0);
        @(negedge clk);
        check_output("lat_t3_led", 32'(led), 32'b0100);
        wait_for_done("lat_done");
        @(negedge clk);
        check_output("lat_q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] zero length");
        apply_stimulus(5'd0);
        check_output("zero_done", 32'(done), 32'd1);
        check_output("zero_busy", 32'(busy), 32'd0);
        check_output("zero_led", 32'(led), 32'd0);
        check_output("zero_no_read", 32'(rd_addr), 32'd2);
        @(negedge clk);
        check_output("zero_done_end", 32'(done), 32'd0);

        $display("[TB] clamp and ignored start");
        done_cnt = 0; max_addr = '0;
        push_exp(4'b0100); push_exp(4'b0000); push_exp(4'b0001); push_exp(4'b0000);
        push_exp(4'b1000); push_exp(4'b0000); push_exp(4'b0010); push_exp(4'b0000);
        apply_stimulus(5'd9);
        wait_for_led("clamp_e1", 4'b0001);
        start = 1'b1; length = 5'd1;
        @(negedge clk);
        start = 1'b0;
        wait_for_done("clamp_done");
        @(negedge clk);
        check_output("clamp_done_cnt", 32'(done_cnt), 32'd1);
        check_output("clamp_max_addr", 32'(max_addr), 32'd3);
        check_output("clamp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] abort");
        done_cnt = 0;
        push_exp(4'b0100); push_exp(4'b0000); push_exp(4'b0001);
        apply_stimulus(5'd4);
        wait_for_led("abort_e1", 4'b0001);
        lit_chk_en = 0;
        push_exp(4'b0000);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_output("abort_led", 32'(led), 32'd0);
        check_output("abort_busy", 32'(busy), 32'd0);
        repeat (60) @(negedge clk);
        check_output("abort_no_done", 32'(done_cnt), 32'd0);
        check_output("abort_q_empty", 32'(exp_q.size()), 32'd0);
        lit_chk_en = 1;
        push_exp(4'b0100); push_exp(4'b0000);
        apply_stimulus(5'd1);
        wait_for_done("post_abort_done");
        @(negedge clk);
        check_output("post_abort_cnt", 32'(done_cnt), 32'd1);
        check_output("post_abort_q", 32'(exp_q.size()), 32'd0);

        $display("[TB] reset mid-ON");
        load_mem(2'd0, 2'd3, 2'd2, 2'd1);
        done_cnt = 0;
        push_exp(4'b0001); push_exp(4'b0000); push_exp(4'b1000); push_exp(4'b0000);
        push_exp(4'b0100); push_exp(4'b0000);
        apply_stimulus(5'd4);
        wait_for_led("rst_mid_e2", 4'b0100);
        lit_chk_en = 0;
        reset = 1'b0;
        @(negedge clk);
        check_output("rst_mid_led", 32'(led), 32'd0);
        check_output("rst_mid_busy", 32'(busy), 32'd0);
        check_output("rst_mid_done", 32'(done), 32'd0);
        check_output("rst_mid_addr", 32'(rd_addr), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        check_output("rst_mid_idle_busy", 32'(busy), 32'd0);
        check_output("rst_mid_no_done", 32'(done_cnt), 32'd0);
        check_output("rst_mid_q_empty", 32'(exp_q.size()), 32'd0);
        lit_chk_en = 1;

        $display("[TB] no gap");
        length_ng = 5'd2;
        start_ng = 1'b1;
        @(negedge clk);
        start_ng = 1'b0;
        g = 0;
        while (led_ng === 4'b0000 && g < 50) begin
            @(negedge clk);
            g++;
        end
        check_output("ng_first_led", 32'(led_ng), 32'b0010);
        count_lit_ticks(t);
        check_output("ng_ticks_e0", 32'(t), 32'd2);
        g = 0;
        while (led_ng === 4'b0000 && g < 50) begin
            @(negedge clk);
            g++;
        end
        check_output("ng_gap_clks", 32'(g), 32'd2);
        check_output("ng_second_led", 32'(led_ng), 32'b0010);
        count_lit_ticks(t);
        check_output("ng_ticks_e1", 32'(t), 32'd2);
        check_output("ng_done", 32'(done_ng), 32'd1);
        check_output("ng_led_off", 32'(led_ng), 32'd0);
        @(negedge clk);
        check_output("ng_done_end", 32'(done_ng), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
